// File: rtl/axi_config_wr.sv
// axi_config_wr
//
// AXI4 write-channel slave that turns one AXI write burst at a time into single-cycle
// register-write strobes (wr/waddr/wdata/wstrb) for a configuration register bank, then
// returns one B response after the final beat.
//
// Optional feature: define AXI_CONFIG_WR_WLAST_CHECK_EN to flag bursts whose wlast does
// not match the awlen-derived last beat. Such bursts complete normally, but B carries SLVERR.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axi_aw*                  write address channel (size/lock/cache/prot/qos/region unused)
//   s_axi_w*                   write data channel (wlast only used by the optional check)
//   s_axi_b*                   write response channel (buser tied to zero)
//   wr                         single-cycle write strobe
//   waddr, wdata, wstrb        register write address/data/byte enables, valid while wr=1

module axi_config_wr #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH    = 8,
   parameter int unsigned ADDR_INCR   = 4,
   parameter int unsigned BUSER_WIDTH = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,

   input  logic [ID_WIDTH-1:0]    s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
   input  logic [7:0]             s_axi_awlen,
   input  logic [2:0]             s_axi_awsize,
   input  logic [1:0]             s_axi_awburst,
   input  logic                   s_axi_awlock,
   input  logic [3:0]             s_axi_awcache,
   input  logic [2:0]             s_axi_awprot,
   input  logic [3:0]             s_axi_awqos,
   input  logic [3:0]             s_axi_awregion,
   input  logic                   s_axi_awvalid,
   output logic                   s_axi_awready,

   input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
   input  logic [STRB_WIDTH-1:0]  s_axi_wstrb,
   input  logic                   s_axi_wlast,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,

   output logic [ID_WIDTH-1:0]    s_axi_bid,
   output logic [1:0]             s_axi_bresp,
   output logic [BUSER_WIDTH-1:0] s_axi_buser,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,

   output logic                   wr,
   output logic [ADDR_WIDTH-1:0]  waddr,
   output logic [DATA_WIDTH-1:0]  wdata,
   output logic [STRB_WIDTH-1:0]  wstrb
);

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

   state_e                state_q, state_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [1:0]            burst_q, burst_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

   logic aw_hs, w_hs, b_hs, last_beat;

   assign aw_hs     = s_axi_awvalid & awready_q;
   assign w_hs      = s_axi_wvalid & wready_q;
   assign b_hs      = s_axi_bready & bvalid_q;
   assign last_beat = (cnt_q == len_q);

`ifdef AXI_CONFIG_WR_WLAST_CHECK_EN
   logic       err_q, err_d;
   logic [1:0] bresp_q, bresp_d;
   logic       unused_ok;
   assign unused_ok = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                        s_axi_awqos, s_axi_awregion};
`else
   logic unused_ok;
   assign unused_ok = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                        s_axi_awqos, s_axi_awregion, s_axi_wlast};
`endif

   always_comb begin
      state_d   = state_q;
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b0;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      burst_d   = burst_q;
      cnt_d     = cnt_q;
      wr_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
`ifdef AXI_CONFIG_WR_WLAST_CHECK_EN
      err_d     = err_q;
      bresp_d   = bresp_q;
`endif
      unique case (state_q)
         StIdle: begin
            // awready_q is still 0 in the first cycle after reset, so no handshake yet.
            awready_d = 1'b1;
            if (aw_hs) begin
               id_d      = s_axi_awid;
               addr_d    = s_axi_awaddr;
               len_d     = s_axi_awlen;
               burst_d   = s_axi_awburst;
               cnt_d     = 8'd0;
`ifdef AXI_CONFIG_WR_WLAST_CHECK_EN
               err_d     = 1'b0;
`endif
               awready_d = 1'b0;
               wready_d  = 1'b1;
               state_d   = StData;
            end
         end
         StData: begin
            wready_d = 1'b1;
            if (w_hs) begin
               // Zero-strobe beats still consume an address slot but do not strobe.
               wr_d    = |s_axi_wstrb;
               waddr_d = addr_q;
               wdata_d = s_axi_wdata;
               wstrb_d = s_axi_wstrb;
               if (burst_q != BurstFixed) begin
                  addr_d = addr_q + ADDR_WIDTH'(ADDR_INCR);
               end
               cnt_d = cnt_q + 8'd1;
`ifdef AXI_CONFIG_WR_WLAST_CHECK_EN
               if (s_axi_wlast != last_beat) begin
                  err_d = 1'b1;
               end
`endif
               if (last_beat) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  state_d  = StResp;
`ifdef AXI_CONFIG_WR_WLAST_CHECK_EN
                  bresp_d  = err_d ? RespSlverr : RespOkay;
`endif
               end
            end
         end
         StResp: begin
            bvalid_d = 1'b1;
            if (b_hs) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         state_q   <= state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

`ifdef AXI_CONFIG_WR_WLAST_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q   <= 1'b0;
         bresp_q <= RespOkay;
      end else begin
         err_q   <= err_d;
         bresp_q <= bresp_d;
      end
   end
   assign s_axi_bresp = bresp_q;
`else
   assign s_axi_bresp = RespOkay;
`endif

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bid     = id_q;
   assign s_axi_buser   = '0;
   assign wr            = wr_q;
   assign waddr         = waddr_q;
   assign wdata         = wdata_q;
   assign wstrb         = wstrb_q;

endmodule

// File: tb/tb_axi_config_wr.sv
module tb_axi_config_wr;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  s_axi_awid = '0;
   logic [31:0] s_axi_awaddr = '0;
   logic [7:0]  s_axi_awlen = '0;
   logic [2:0]  s_axi_awsize = 3'd2;
   logic [1:0]  s_axi_awburst = '0;
   logic        s_axi_awlock = 1'b0;
   logic [3:0]  s_axi_awcache = '0;
   logic [2:0]  s_axi_awprot = '0;
   logic [3:0]  s_axi_awqos = '0;
   logic [3:0]  s_axi_awregion = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wlast = 1'b0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [7:0]  s_axi_bid;
   logic [1:0]  s_axi_bresp;
   logic [0:0]  s_axi_buser;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;
   logic        wr;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   axi_config_wr dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
      .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
      .s_axi_awregion(s_axi_awregion), .s_axi_awvalid(s_axi_awvalid),
      .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_exp_t;

   typedef struct {
      logic [7:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [31:0] seed;
      logic [3:0]  strb;
      int          zero_beat;
      logic [1:0]  exp_resp;
   } vec_t;

   wr_exp_t exp_q[$];
   wr_exp_t mon_e;
   vec_t    vecs[6];
   int      tests = 0;
   int      failed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every wr pulse must match the oldest outstanding expected register write.
   always @(negedge clk) begin
      if (rst_n && wr) begin
         if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL wr_unexpected: got wr at %0h, expected no pulse", waddr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", waddr, mon_e.addr);
            chk("wr_data", wdata, mon_e.data);
            chk("wr_strb", {28'd0, wstrb}, {28'd0, mon_e.strb});
         end
      end
   end

   // All drivers below start and end at posedge + 1.
   task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      int n = 0;
      s_axi_awid    = id;
      s_axi_awaddr  = addr;
      s_axi_awlen   = len;
      s_axi_awburst = burst;
      s_axi_awvalid = 1'b1;
      while (!s_axi_awready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!s_axi_awready) chk("aw_timeout", {31'd0, s_axi_awready}, 32'd1);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                         input logic [31:0] exp_addr);
      int n = 0;
      wr_exp_t e;
      s_axi_wdata  = data;
      s_axi_wstrb  = strb;
      s_axi_wlast  = last;
      s_axi_wvalid = 1'b1;
      while (!s_axi_wready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!s_axi_wready) chk("w_timeout", {31'd0, s_axi_wready}, 32'd1);
      if (strb != 4'h0) begin
         e.addr = exp_addr;
         e.data = data;
         e.strb = strb;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0;
   endtask

   task automatic wait_b(input logic [7:0] id, input logic [1:0] resp);
      int n = 0;
      s_axi_bready = 1'b1;
      while (!s_axi_bvalid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b_valid", {31'd0, s_axi_bvalid}, 32'd1);
      chk("b_id", {24'd0, s_axi_bid}, {24'd0, id});
      chk("b_resp", {30'd0, s_axi_bresp}, {30'd0, resp});
      @(posedge clk); #1;
      s_axi_bready = 1'b0;
      chk("awready_after_b", {31'd0, s_axi_awready}, 32'd1);
      chk("bvalid_after_b", {31'd0, s_axi_bvalid}, 32'd0);
   endtask

   // Reference address model: FIXED holds, everything else increments by 4 modulo 2^32.
   task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] seed,
                            input logic [3:0] strb, input int zero_beat, input int bad_last);
      logic [31:0] a;
      a = addr;
      send_aw(id, addr, len, burst);
      for (int b = 0; b <= int'(len); b++) begin
         send_w(seed ^ (b * 32'h0101_0101), (b == zero_beat) ? 4'h0 : strb,
                (b == int'(len)) ^ (b == bad_last), a);
         if (burst != 2'b00) a = a + 32'd4;
      end
   endtask

   initial begin
      vecs[0] = '{8'h11, 32'h0000_0100, 8'd0,   2'b01, 32'hDEAD_BEEF, 4'hF, -1, 2'b00};
      vecs[1] = '{8'h22, 32'h0000_1000, 8'd3,   2'b01, 32'h1234_5678, 4'hF, -1, 2'b00};
      vecs[2] = '{8'h33, 32'h0000_0020, 8'd2,   2'b00, 32'hA5A5_0000, 4'h3,  1, 2'b00};
      vecs[3] = '{8'h44, 32'hFFFF_FFF8, 8'd3,   2'b10, 32'h0BAD_F00D, 4'hC, -1, 2'b00};
      vecs[4] = '{8'h55, 32'h0000_0040, 8'd1,   2'b11, 32'h7777_0001, 4'h1, -1, 2'b00};
      vecs[5] = '{8'h66, 32'h0000_0000, 8'd255, 2'b01, 32'hC0DE_0000, 4'hF, -1, 2'b00};

      // Reset values while rst_n is low.
      #3;
      chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
      chk("rst_wready", {31'd0, s_axi_wready}, 32'd0);
      chk("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
      chk("rst_bid", {24'd0, s_axi_bid}, 32'd0);
      chk("rst_bresp", {30'd0, s_axi_bresp}, 32'd0);
      chk("rst_wr", {31'd0, wr}, 32'd0);
      chk("rst_waddr", waddr, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("awready_before_edge", {31'd0, s_axi_awready}, 32'd0);
      @(posedge clk); #1;
      chk("awready_after_release", {31'd0, s_axi_awready}, 32'd1);

      // Early W data must stall until the AW handshake.
      s_axi_wdata  = 32'hFEED_0001;
      s_axi_wstrb  = 4'hF;
      s_axi_wlast  = 1'b1;
      s_axi_wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("early_w_stall", {31'd0, s_axi_wready}, 32'd0);
      end
      send_aw(8'h5A, 32'h0000_0500, 8'd0, 2'b01);
      send_w(32'hFEED_0001, 4'hF, 1'b1, 32'h0000_0500);
      wait_b(8'h5A, 2'b00);

      // Table-driven bursts.
      foreach (vecs[i]) begin
         run_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].seed,
                   vecs[i].strb, vecs[i].zero_beat, -1);
         wait_b(vecs[i].id, vecs[i].exp_resp);
      end

      // Final beat: bvalid rises with the last wr; bready held low for 5 cycles.
      run_burst(8'h77, 32'h0000_0800, 8'd0, 2'b01, 32'h0000_0077, 4'hF, -1, -1);
      chk("last_wr", {31'd0, wr}, 32'd1);
      chk("last_wready", {31'd0, s_axi_wready}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         chk("hold_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
         chk("hold_bid", {24'd0, s_axi_bid}, 32'h77);
         chk("hold_awready", {31'd0, s_axi_awready}, 32'd0);
         @(posedge clk); #1;
      end
      wait_b(8'h77, 2'b00);

`ifdef AXI_CONFIG_WR_WLAST_CHECK_EN
      run_burst(8'h88, 32'h0000_0300, 8'd1, 2'b01, 32'h8888_0000, 4'hF, -1, 0);
      wait_b(8'h88, 2'b10);
      run_burst(8'h89, 32'h0000_0310, 8'd1, 2'b01, 32'h8989_0000, 4'hF, -1, -1);
      wait_b(8'h89, 2'b00);
`else
      run_burst(8'h88, 32'h0000_0300, 8'd1, 2'b01, 32'h8888_0000, 4'hF, -1, 0);
      wait_b(8'h88, 2'b00);
`endif

      // Reset after beat 2 of an 8-beat burst drops everything.
      send_aw(8'h99, 32'h0000_0900, 8'd7, 2'b01);
      for (int b = 0; b < 3; b++) begin
         send_w(32'h9900_0000 + b, 4'hF, 1'b0, 32'h0000_0900 + 32'(b * 4));
      end
      chk("pre_reset_wr", {31'd0, wr}, 32'd1);
      rst_n = 1'b0;
      s_axi_wvalid = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_wr", {31'd0, wr}, 32'd0);
      chk("mid_rst_wready", {31'd0, s_axi_wready}, 32'd0);
      chk("mid_rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
      chk("mid_rst_waddr", waddr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_rst_awready_low", {31'd0, s_axi_awready}, 32'd0);
      @(posedge clk); #1;
      chk("post_rst_awready", {31'd0, s_axi_awready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_no_b", {31'd0, s_axi_bvalid}, 32'd0);
      end
      run_burst(8'hAA, 32'h0000_0A00, 8'd2, 2'b01, 32'hAAAA_0000, 4'hF, -1, -1);
      wait_b(8'hAA, 2'b00);

      repeat (3) @(posedge clk);
      #1 chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
